// File: rtl/debug_clk_gen.sv
// Debug clock generator: one divided, glitch-free waveform fanned out
// to gated channels, with stop, free-run, single-step and burst modes.
module debug_clk_gen #(
  parameter int COUNTER_BITS = 32,
  parameter int BURST_BITS   = 16,
  parameter int NUM_CH       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [COUNTER_BITS-1:0] divider,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    step,
  input  logic                    start,
  input  logic [BURST_BITS-1:0]   burst_len,
  output logic [NUM_CH-1:0]       clk_o,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [1:0] M_AUTO  = 2'd1;
  localparam logic [1:0] M_STEP  = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  state_t                  state, state_nxt;
  logic [COUNTER_BITS-1:0] cnt, cnt_nxt;
  logic [COUNTER_BITS-1:0] per, per_nxt;
  logic [NUM_CH-1:0]       mask, mask_nxt;
  logic [BURST_BITS-1:0]   rem, rem_nxt;
  logic                    auto_run, auto_nxt;
  logic                    s1, s2, s3;
  logic [2:0]              prime;
  logic                    rise;
  logic                    load;
  logic                    last;
  logic [COUNTER_BITS-1:0] p_new;
  logic [NUM_CH-1:0]       clk_nxt;

  // prime gates edge detection until s3 holds a real post-reset sample,
  // so a step held high across reset is not seen as an edge
  assign rise  = prime[2] & s2 & ~s3;
  assign p_new = (divider < COUNTER_BITS'(2)) ? COUNTER_BITS'(2) : divider;
  assign last  = (cnt == per - COUNTER_BITS'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    per_nxt   = per;
    mask_nxt  = mask;
    rem_nxt   = rem;
    auto_nxt  = auto_run;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (mode)
          M_AUTO: begin
            state_nxt = RUN;
            auto_nxt  = 1'b1;
            load      = 1'b1;
          end
          M_STEP: begin
            if (rise) begin
              state_nxt = RUN;
              auto_nxt  = 1'b0;
              rem_nxt   = BURST_BITS'(1);
              load      = 1'b1;
            end
          end
          M_BURST: begin
            if (start && burst_len != '0) begin
              state_nxt = RUN;
              auto_nxt  = 1'b0;
              rem_nxt   = burst_len;
              load      = 1'b1;
            end else if (start) begin
              state_nxt = FINISH;
            end
          end
          default: ;
        endcase
      end
      RUN: begin
        if (!last) begin
          cnt_nxt = cnt + COUNTER_BITS'(1);
        end else if (auto_run) begin
          if (mode == M_AUTO) load = 1'b1;
          else state_nxt = IDLE;
        end else if (rem <= BURST_BITS'(1)) begin
          rem_nxt   = '0;
          state_nxt = FINISH;
        end else begin
          rem_nxt = rem - BURST_BITS'(1);
          load    = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      cnt_nxt  = '0;
      per_nxt  = p_new;
      mask_nxt = ch_enable;
    end
  end

  always_comb begin
    clk_nxt = '0;
    if (state == RUN && cnt < (per >> 1)) clk_nxt = mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      per      <= '0;
      mask     <= '0;
      rem      <= '0;
      auto_run <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      prime    <= '0;
      clk_o    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      per      <= per_nxt;
      mask     <= mask_nxt;
      rem      <= rem_nxt;
      auto_run <= auto_nxt;
      s1       <= step;
      s2       <= s1;
      s3       <= s2;
      prime    <= {prime[1:0], 1'b1};
      clk_o    <= clk_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_debug_clk_gen.sv
// Randomized bench for debug_clk_gen against a period-queue model
// that expands each accepted trigger into per-cycle expectations.
module tb_debug_clk_gen;

  localparam int CB = 32;
  localparam int BB = 16;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [CB-1:0] divider;
  logic [NC-1:0] ch_enable;
  logic          step;
  logic          start;
  logic [BB-1:0] burst_len;
  logic [NC-1:0] clk_o;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  debug_clk_gen #(
    .COUNTER_BITS(CB),
    .BURST_BITS(BB),
    .NUM_CH(NC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .divider(divider),
    .ch_enable(ch_enable),
    .step(step),
    .start(start),
    .burst_len(burst_len),
    .clk_o(clk_o),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    bit            run;
    bit            fin;
    bit            last;
    bit            auto_p;
    logic [NC-1:0] hi;
  } ent_t;

  ent_t          q[$];
  ent_t          cur;
  ent_t          idle_e;
  int            rem;
  bit            sh[$];
  logic [NC-1:0] e_clk;
  bit            e_busy;
  bit            e_done;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_period(bit a);
    int p = (divider < 2) ? 2 : int'(divider);
    for (int i = 0; i < p; i++) begin
      ent_t e;
      e.run    = 1'b1;
      e.fin    = 1'b0;
      e.last   = (i == p - 1);
      e.auto_p = a;
      e.hi     = (i < p / 2) ? ch_enable : '0;
      q.push_back(e);
    end
  endtask

  task automatic push_fin();
    ent_t e = idle_e;
    e.fin = 1'b1;
    q.push_back(e);
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    ent_t old = cur;
    int   sz  = sh.size();
    bit   rise;
    if (reset) begin
      q.delete();
      sh.delete();
      cur    = idle_e;
      rem    = 0;
      e_clk  = '0;
      e_busy = 1'b0;
      e_done = 1'b0;
      return;
    end
    rise = (sz >= 3) && sh[sz-2] && !sh[sz-3];
    sh.push_back(step);
    if (sh.size() > 4) sh.delete(0);
    if (q.size() == 0) begin
      if (old.run && old.last) begin
        if (old.auto_p) begin
          if (mode == 2'd1) push_period(1'b1);
        end else if (rem > 0) begin
          rem--;
          push_period(1'b0);
        end else begin
          push_fin();
        end
      end else if (!old.run && !old.fin) begin
        if (mode == 2'd1) begin
          push_period(1'b1);
        end else if (mode == 2'd2 && rise) begin
          rem = 0;
          push_period(1'b0);
        end else if (mode == 2'd3 && start) begin
          if (burst_len != 0) begin
            rem = int'(burst_len) - 1;
            push_period(1'b0);
          end else begin
            push_fin();
          end
        end
      end
    end
    cur    = (q.size() > 0) ? q.pop_front() : idle_e;
    e_clk  = old.run ? old.hi : '0;
    e_busy = cur.run | cur.fin;
    e_done = cur.fin;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("clk_o", 32'(clk_o), 32'(e_clk));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  initial begin
    idle_e    = '{run: 1'b0, fin: 1'b0, last: 1'b0, auto_p: 1'b0, hi: '0};
    cur       = idle_e;
    rem       = 0;
    reset     = 1'b1;
    mode      = 2'd0;
    divider   = 4;
    ch_enable = '0;
    step      = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    run(3);
    reset = 1'b0;
    run(2);

    ch_enable = 4'b0101;
    mode      = 2'd1;
    run(30);
    mode = 2'd0;
    run(6);

    divider = 6;
    mode    = 2'd2;
    step    = 1'b1;
    run(4);
    step = 1'b0;
    run(1);
    step = 1'b1;
    run(15);
    step = 1'b0;
    run(10);

    divider   = 3;
    mode      = 2'd3;
    burst_len = 5;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(25);
    burst_len = 0;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(4);

    divider   = 10;
    ch_enable = 4'b1111;
    mode      = 2'd1;
    run(4);
    divider   = 2;
    ch_enable = 4'b0000;
    run(20);
    ch_enable = 4'b1011;
    run(10);
    mode = 2'd0;
    run(5);

    divider   = 4;
    burst_len = 8;
    mode      = 2'd3;
    start     = 1'b1;
    run(1);
    start = 1'b0;
    run(9);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(3);
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(40);

    mode    = 2'd1;
    divider = 0;
    run(10);
    divider = 1;
    run(10);
    mode = 2'd0;
    run(4);

    step = 1'b1;
    mode = 2'd2;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(12);
    step = 1'b0;
    run(4);

    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) divider = CB'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) ch_enable = NC'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) step = ~step;
      if ($urandom_range(0, 19) == 0) burst_len = BB'($urandom_range(0, 4));
      start = ($urandom_range(0, 14) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
